// File: rtl/dma_burst_pkg.sv
// Shared state type, AXI burst encodings, page/FIXED limits and the strobe
// helper used by the dma_burst_gen burst splitter.
package dma_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] BURST_FIXED     = 2'd0;
    localparam logic [1:0] BURST_INCR      = 2'd1;
    localparam int         FIXED_MAX_BEATS = 16;
    localparam int         PAGE_BYTES      = 4096;

    // Sets lanes [lo, lo+cnt); callers truncate the result to their bus width.
    function automatic logic [63:0] strb_mask(input logic [6:0] lo, input logic [6:0] cnt);
        logic [63:0] m;
        logic [7:0]  hi;
        hi = {1'b0, lo} + {1'b0, cnt};
        for (int i = 0; i < 64; i++)
            m[i] = (8'(i) >= {1'b0, lo}) && (8'(i) < hi);
        return m;
    endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational sizing of the next AXI burst: beat count, byte strobe and the
// number of descriptor bytes the burst consumes.
module dma_burst_calc
    import dma_burst_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int LEN_W      = 32
) (
    input  logic [11:0]           addr_lo,
    input  logic [LEN_W-1:0]      bytes,
    input  logic                  fixed_mode,
    input  logic [7:0]            maxb,
    output logic [7:0]            len,
    output logic [DATA_BYTES-1:0] strb,
    output logic [LEN_W-1:0]      xfer
);

    localparam int OFF_W = $clog2(DATA_BYTES);
    localparam int CW    = (LEN_W > 16) ? LEN_W : 16;

    logic [OFF_W-1:0] off;
    logic [CW-1:0]    bytes_w;
    logic [CW-1:0]    words;
    logic [CW-1:0]    page_beats;
    logic [CW-1:0]    beats;
    logic [CW-1:0]    head;
    logic [CW-1:0]    part;

    assign off     = addr_lo[OFF_W-1:0];
    assign bytes_w = CW'(bytes);

    // Partial head/tail beats are single-beat; otherwise take the tightest cap.
    always_comb begin
        words      = bytes_w >> OFF_W;
        page_beats = (CW'(PAGE_BYTES) - CW'(addr_lo)) >> OFF_W;
        beats      = words;
        if (beats > CW'(maxb) + CW'(1))
            beats = CW'(maxb) + CW'(1);
        if (beats > page_beats)
            beats = page_beats;
        if (fixed_mode && beats > CW'(FIXED_MAX_BEATS))
            beats = CW'(FIXED_MAX_BEATS);

        head = CW'(DATA_BYTES) - CW'(off);
        part = bytes_w;
        if (off != '0 && head < bytes_w)
            part = head;

        len  = '0;
        strb = '1;
        xfer = LEN_W'(beats << OFF_W);
        if (off != '0 || bytes_w < CW'(DATA_BYTES)) begin
            strb = DATA_BYTES'(strb_mask(7'(off), 7'(part)));
            xfer = LEN_W'(part);
        end else begin
            len = 8'(beats - CW'(1));
        end
    end

endmodule

// File: rtl/dma_burst_gen.sv
// DMA AXI burst generator: splits one descriptor into legal address requests
// with outstanding-burst limiting. Define DMA_BURST_PERF_EN for perf counters.
module dma_burst_gen
    import dma_burst_pkg::*;
#(
    parameter int  DATA_BYTES = 4,
    parameter int  ADDR_W     = 32,
    parameter int  LEN_W      = 32,
    parameter int  N_CH       = 8,
    parameter int  MAX_OUTST  = 4,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid_i,
    output logic                  start_ready_o,
    input  logic [CH_W-1:0]       start_ch_i,
    input  logic [ADDR_W-1:0]     desc_addr_i,
    input  logic [LEN_W-1:0]      desc_bytes_i,
    input  logic                  desc_fixed_i,
    input  logic [7:0]            maxb_i,
    input  logic                  abort_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ADDR_W-1:0]     req_addr_o,
    output logic [7:0]            req_len_o,
    output logic [2:0]            req_size_o,
    output logic [1:0]            req_burst_o,
    output logic [DATA_BYTES-1:0] req_strb_o,
    output logic [CH_W-1:0]       req_ch_o,
    input  logic                  resp_valid_i,
    output logic                  busy_o,
    output logic                  done_o,
`ifdef DMA_BURST_PERF_EN
    output logic [31:0]           perf_bursts_o,
    output logic [LEN_W-1:0]      perf_bytes_o,
`endif
    output logic                  aborted_o
);

    localparam int OFF_W = $clog2(DATA_BYTES);

    state_t            state, state_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  rem_bytes;
    logic              fixed_q;
    logic [CH_W-1:0]   ch_q;
    logic [3:0]        outst, outst_next;
    logic              aborted_q;

    logic              hs, accept, abort_hit, room, slot_free, load;
    logic [ADDR_W-1:0] calc_addr;
    logic [LEN_W-1:0]  calc_bytes;
    logic              calc_fixed;
    logic [CH_W-1:0]   calc_ch;
    logic [7:0]        c_len;
    logic [DATA_BYTES-1:0] c_strb;
    logic [LEN_W-1:0]  c_xfer;

    assign hs        = req_valid_o && req_ready_i;
    assign accept    = start_valid_i && start_ready_o;
    assign abort_hit = abort_i || aborted_q;
    assign slot_free = !req_valid_o || hs;
    assign room      = outst_next < 4'(MAX_OUTST);

    // The first burst is sized straight from the descriptor so it can be
    // registered on the same edge that accepts the job.
    assign calc_addr  = (state == ST_IDLE) ? desc_addr_i  : cur_addr;
    assign calc_bytes = (state == ST_IDLE) ? desc_bytes_i : rem_bytes;
    assign calc_fixed = (state == ST_IDLE) ? desc_fixed_i : fixed_q;
    assign calc_ch    = (state == ST_IDLE) ? start_ch_i   : ch_q;

    dma_burst_calc #(
        .DATA_BYTES (DATA_BYTES),
        .LEN_W      (LEN_W)
    ) u_calc (
        .addr_lo    (calc_addr[11:0]),
        .bytes      (calc_bytes),
        .fixed_mode (calc_fixed),
        .maxb       (maxb_i),
        .len        (c_len),
        .strb       (c_strb),
        .xfer       (c_xfer)
    );

    always_comb begin
        outst_next = outst;
        if (hs && !resp_valid_i)
            outst_next = outst + 4'd1;
        else if (!hs && resp_valid_i && outst != '0)
            outst_next = outst - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        load          = 1'b0;
        start_ready_o = 1'b0;
        busy_o        = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready_o = !done_o;
                if (start_valid_i && !done_o) begin
                    state_next = (desc_bytes_i == '0) ? ST_DRAIN : ST_ISSUE;
                    load       = (desc_bytes_i != '0) && room;
                end
            end
            ST_ISSUE: begin
                busy_o = 1'b1;
                if (slot_free && (rem_bytes == '0 || abort_hit))
                    state_next = ST_DRAIN;
                else if (slot_free && room)
                    load = 1'b1;
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
                if (outst == '0)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The job pointer is advanced when a burst is loaded, so it always names
    // the burst after the one currently presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr    <= '0;
            rem_bytes   <= '0;
            fixed_q     <= 1'b0;
            ch_q        <= '0;
            outst       <= '0;
            aborted_q   <= 1'b0;
            done_o      <= 1'b0;
            aborted_o   <= 1'b0;
            req_valid_o <= 1'b0;
            req_addr_o  <= '0;
            req_len_o   <= '0;
            req_size_o  <= '0;
            req_burst_o <= '0;
            req_strb_o  <= '0;
            req_ch_o    <= '0;
        end else begin
            outst     <= outst_next;
            done_o    <= (state == ST_DRAIN) && (outst == '0);
            aborted_o <= (state == ST_DRAIN) && (outst == '0) && (aborted_q || abort_i);
            if (accept) begin
                cur_addr  <= desc_addr_i;
                rem_bytes <= desc_bytes_i;
                fixed_q   <= desc_fixed_i;
                ch_q      <= start_ch_i;
                aborted_q <= 1'b0;
            end else if (state != ST_IDLE && abort_i) begin
                aborted_q <= 1'b1;
            end
            if (load) begin
                req_valid_o <= 1'b1;
                req_addr_o  <= {calc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                req_len_o   <= c_len;
                req_size_o  <= 3'(OFF_W);
                req_burst_o <= calc_fixed ? BURST_FIXED : BURST_INCR;
                req_strb_o  <= c_strb;
                req_ch_o    <= calc_ch;
                cur_addr    <= calc_fixed ? calc_addr : calc_addr + ADDR_W'(c_xfer);
                rem_bytes   <= calc_bytes - c_xfer;
            end else if (hs) begin
                req_valid_o <= 1'b0;
            end
        end
    end

`ifdef DMA_BURST_PERF_EN
    logic [LEN_W-1:0] req_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_xfer      <= '0;
            perf_bursts_o <= '0;
            perf_bytes_o  <= '0;
        end else begin
            if (load)
                req_xfer <= c_xfer;
            if (hs) begin
                perf_bursts_o <= perf_bursts_o + 32'd1;
                perf_bytes_o  <= perf_bytes_o + req_xfer;
            end
        end
    end
`endif

endmodule

// File: doc/dma_burst_gen.md
# dma_burst_gen

Parametrised AXI read/write burst generator for the DMA streaming path. It accepts one descriptor per job from any of `N_CH` channels and splits the descriptor's byte range into legal AXI address-channel requests. Splitting respects data-bus width, address alignment, the software burst cap, 4 KB boundaries and FIXED-mode length limits. Unlike the single-beat-width streamer, it has a ready/valid request port, bounded outstanding-burst tracking, and a channel tag on every request.

## Interface
- `DATA_BYTES`, 4: bytes per data beat; power of two, 4..64.
- `ADDR_W`, 32: address width.
- `LEN_W`, 32: descriptor byte-count width.
- `N_CH`, 8: number of channels; `CH_W = max(1, $clog2(N_CH))`.
- `MAX_OUTST`, 4: maximum issued-but-uncompleted bursts, 1..15.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start_valid_i` / `start_ready_o`  in/out  1  descriptor handshake.
- `start_ch_i`  in  CH_W  channel of the descriptor.
- `desc_addr_i`  in  ADDR_W  start byte address.
- `desc_bytes_i`  in  LEN_W  byte count.
- `desc_fixed_i`  in  1  1 = FIXED burst mode, 0 = INCR.
- `maxb_i`  in  8  maximum AXI LEN, i.e. beats−1.
- `abort_i`  in  1  level abort of the current job.
- `req_valid_o` / `req_ready_i`  out/in  1  request handshake.
- `req_addr_o`  out  ADDR_W  burst address, aligned to `DATA_BYTES`.
- `req_len_o`  out  8  AXI LEN.
- `req_size_o`  out  3  `log2(DATA_BYTES)`.
- `req_burst_o`  out  2  0 = FIXED, 1 = INCR.
- `req_strb_o`  out  DATA_BYTES  byte strobe; all ones for multi-beat bursts.
- `req_ch_o`  out  CH_W  channel tag.
- `resp_valid_i`  in  1  one burst completed.
- `busy_o`  out  1  job in progress.
- `done_o`  out  1  one-cycle job-complete pulse.
- `aborted_o`  out  1  qualifies `done_o`; set when the job ended by abort.

## Operation
- FSM states:
  - IDLE: `start_ready_o`=1. On handshake, capture addr, bytes, mode and channel, then go to ISSUE. If bytes=0, go directly to DRAIN.
  - ISSUE: present bursts. Go to DRAIN when the remaining bytes reach 0 on a handshake, or when abort is seen with no request pending.
  - DRAIN: wait until outstanding=0, then pulse `done_o` and return to IDLE.
- Burst calculation, with `off = addr mod DATA_BYTES`:
  - `off≠0`: single beat. Strobe covers `min(DATA_BYTES−off, bytes)` bytes starting at lane `off`.
  - `off=0` and `bytes<DATA_BYTES`: single beat. Strobe covers the low `bytes` lanes.
  - Otherwise: `beats = min(bytes/DATA_BYTES, maxb_i+1, (4096−addr[11:0])/DATA_BYTES, 16 if FIXED)`, and `LEN = beats−1`.
- After each handshake:
  - bytes −= bytes transferred.
  - addr += bytes transferred in INCR mode; addr is unchanged in FIXED mode.
- Outstanding counter:
  - +1 on each request handshake, −1 on each `resp_valid_i`.
  - A handshake and a response in the same cycle leave it unchanged.
  - A `resp_valid_i` at count 0 is ignored.
  - `req_valid_o` is held low while count = `MAX_OUTST` and no response arrives that cycle.
- Abort:
  - A request already valid stays valid, with stable fields, until accepted.
  - No further requests are issued after that.
  - The FSM then goes to DRAIN and `aborted_o`=1 with `done_o`.
  - Abort in IDLE or DRAIN has no effect apart from setting the aborted flag during DRAIN.
- `maxb_i` is sampled per burst. `req_*` fields are stable while valid and not ready.

## Timing
- Reset values: state IDLE, `start_ready_o`=1; all other outputs 0, including `req_*`, `busy_o`, `done_o`, `aborted_o`; counters 0.
- Reset mid-job discards the job and all outstanding state immediately.
- All `req_*` outputs are registered. The first `req_valid_o` appears 1 cycle after the start handshake.
- On handshake, the next burst is loaded on the same edge, giving back-to-back issue at 1 request/cycle.
- `done_o` appears 1 cycle after the cycle in which outstanding reaches 0 in DRAIN.
- A zero-byte job gives `done_o` 2 cycles after start.
- `start_ready_o`=0 from the cycle after acceptance until the cycle after `done_o`.

## Configuration
- `DMA_BURST_PERF_EN` defined: adds `perf_bursts_o` (32) and `perf_bytes_o` (LEN_W) outputs.
  - Both are cleared by `rst`, increment on every request handshake, and wrap at maximum.
- Not defined: these ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Package `dma_burst_pkg`:
  - state enum;
  - `BURST_FIXED`/`BURST_INCR` constants;
  - `FIXED_MAX_BEATS`=16 and `PAGE_BYTES`=4096;
  - strobe-build function.
- Sub-module `dma_burst_calc`: combinational calculation of beats, strobe and transferred byte count from (addr, bytes, mode, maxb).

## Test plan
- DATA_BYTES=4, maxb=255, INCR, addr 0x1000, bytes 64 → one request: addr 0x1000, len 15, strb 0xF. After one resp → `done_o`, `aborted_o`=0.
- Addr 0x1002, bytes 10 → requests (0x1000, len 0, strb 0xC) then (0x1004, len 1, strb 0xF).
- Addr 0x0FF0, bytes 64 → (0x0FF0, len 3) then (0x1000, len 11).
- FIXED mode, addr 0x2000, bytes 128 → two requests at 0x2000, each len 15, burst 0.
- `MAX_OUTST`=2, `req_ready_i`=1, no responses → exactly 2 handshakes. After one `resp_valid_i`, the 3rd request issues the next cycle.
- Abort asserted while `req_valid_o`=1 and `req_ready_i`=0 → the request stays stable until accepted, nothing further is issued, and `done_o`+`aborted_o` follow after the outstanding count drains.
